// File: rtl/pll_lock_ctrl_pkg.sv
// Shared constants and helpers for the PLL lock supervisor.
// State encodings are plain constants so older tools and netlists can read them.
package pll_lock_pkg;

  localparam int unsigned RELOCK_W = 8;
  localparam int unsigned RETRY_W  = 8;
  localparam int unsigned STATE_W  = 3;

  localparam logic [STATE_W-1:0] ST_RESET_PLL = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] ST_STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT     = 3'd4;

  // Width of the shared phase counter: must hold the largest terminal count.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// PLL-side and system-side signals of the lock supervisor.
// master = supervisor, slave = PLL wrapper / system environment.
interface pll_lock_ctrl_if;
  import pll_lock_pkg::*;

  logic                pll_locked;
  logic                clear_fault;
  logic                pll_rst;
  logic                sys_rst;
  logic                ready;
  logic                fault;
  logic [RELOCK_W-1:0] relock_cnt;

  modport master (
    input  pll_locked, clear_fault,
    output pll_rst, sys_rst, ready, fault, relock_cnt
  );

  modport slave (
    output pll_locked, clear_fault,
    input  pll_rst, sys_rst, ready, fault, relock_cnt
  );

endinterface

// File: rtl/pll_lock_ctrl_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by a synchronous reset.
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock, retries on timeout
// and releases the downstream system reset only after a stable lock.
module pll_lock_ctrl
  import pll_lock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned MAX_RETRIES      = 7
) (
  input  logic             refclk,
  input  logic             rst,
  pll_lock_ctrl_if.master  bus
);

  localparam int unsigned CNT_W = cnt_width(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);

  localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic [STATE_W-1:0]  r_state;
  logic [STATE_W-1:0]  w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [RETRY_W-1:0]  r_retry;
  logic [RETRY_W-1:0]  w_retry_nxt;
  logic [RETRY_W-1:0]  w_retry_inc;
  logic [RELOCK_W-1:0] r_relock;
  logic [RELOCK_W-1:0] w_relock_nxt;
  logic                r_pll_rst;
  logic                r_sys_rst;
  logic                r_ready;
  logic                r_fault;
  logic                w_pll_rst_nxt;
  logic                w_sys_rst_nxt;
  logic                w_ready_nxt;
  logic                w_fault_nxt;
  logic                w_locked_s;

  sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_locked (
    .clk (refclk),
    .rst (rst),
    .i_d (bus.pll_locked),
    .o_q (w_locked_s)
  );

  assign w_retry_inc = r_retry + RETRY_W'(1);

  // Next-state, counter and registered-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_retry_nxt  = r_retry;
    w_relock_nxt = r_relock;

    case (r_state)
      ST_RESET_PLL: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == RST_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_locked_s) begin
          w_state_nxt = ST_STABLE;
        end else if (r_cnt == TMO_LAST) begin
          w_retry_nxt = w_retry_inc;
          w_state_nxt = (w_retry_inc == RETRY_MAX) ? ST_FAULT : ST_RESET_PLL;
        end
      end

      ST_STABLE: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == STB_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_RESET_PLL;
          if (r_relock != '1) begin
            w_relock_nxt = r_relock + RELOCK_W'(1);
          end
        end
      end

      ST_FAULT: begin
        if (bus.clear_fault) begin
          w_state_nxt = ST_RESET_PLL;
          w_retry_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = ST_RESET_PLL;
      end
    endcase

    // Every state entry restarts the shared counter; a fresh RUN forgives past retries.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
      if (w_state_nxt == ST_RUN) begin
        w_retry_nxt = '0;
      end
    end

    w_pll_rst_nxt = (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
    w_sys_rst_nxt = (w_state_nxt != ST_RUN);
    w_ready_nxt   = (w_state_nxt == ST_RUN);
    w_fault_nxt   = (w_state_nxt == ST_FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state   <= ST_RESET_PLL;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_relock  <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_retry   <= w_retry_nxt;
      r_relock  <= w_relock_nxt;
      r_pll_rst <= w_pll_rst_nxt;
      r_sys_rst <= w_sys_rst_nxt;
      r_ready   <= w_ready_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign bus.pll_rst    = r_pll_rst;
  assign bus.sys_rst    = r_sys_rst;
  assign bus.ready      = r_ready;
  assign bus.fault      = r_fault;
  assign bus.relock_cnt = r_relock;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small timing parameters.
`timescale 1ns/1ps
module tb_pll_lock_ctrl;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pll_lock_ctrl_if bus ();

  pll_lock_ctrl #(
    .SYNC_STAGES      (2),
    .RST_PULSE_CYC    (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (32),
    .MAX_RETRIES      (2)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #10 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Hold rst for two edges; returns on the negedge where rst is released.
  task automatic restart(input logic lk);
    rst = 1'b1;
    bus.pll_locked  = lk;
    bus.clear_fault = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge refclk);
      if (bus.ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on the negedge right after a one-cycle rst pulse with pll_locked held high.
  task automatic check_restart(input string tag);
    chk({tag, "_pll_rst"}, bus.pll_rst, 1);
    chk({tag, "_sys_rst"}, bus.sys_rst, 1);
    chk({tag, "_ready"},   bus.ready,   0);
    chk({tag, "_relock"},  bus.relock_cnt, 0);
    rst = 1'b0;
    tick(3);
    chk({tag, "_pulse_hi"}, bus.pll_rst, 1);
    tick(1);
    chk({tag, "_pulse_lo"}, bus.pll_rst, 0);
    tick(8);
    chk({tag, "_ready_early"}, bus.ready, 0);
    tick(1);
    chk({tag, "_ready_on"}, bus.ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit bad;

    // 1: reset values and basic lock-up
    bus.pll_locked  = 1'b0;
    bus.clear_fault = 1'b0;
    tick(2);
    chk("rst_pll_rst", bus.pll_rst, 1);
    chk("rst_sys_rst", bus.sys_rst, 1);
    chk("rst_ready",   bus.ready, 0);
    chk("rst_fault",   bus.fault, 0);
    chk("rst_relock",  bus.relock_cnt, 0);
    rst = 1'b0;
    tick(3);
    chk("t1_pulse_hi", bus.pll_rst, 1);
    tick(1);
    chk("t1_pulse_lo", bus.pll_rst, 0);
    tick(9);
    bus.pll_locked = 1'b1;
    tick(10);
    chk("t1_ready_early", bus.ready, 0);
    chk("t1_sysrst_early", bus.sys_rst, 1);
    tick(1);
    chk("t1_ready", bus.ready, 1);
    chk("t1_sys_rst", bus.sys_rst, 0);
    chk("t1_relock", bus.relock_cnt, 0);

    // 6b: clear_fault in RUN does nothing
    bus.clear_fault = 1'b1;
    tick(1);
    bus.clear_fault = 1'b0;
    tick(1);
    chk("t6_clr_run_ready", bus.ready, 1);
    chk("t6_clr_run_fault", bus.fault, 0);
    chk("t6_clr_run_pll",   bus.pll_rst, 0);

    // 2: one-cycle lock glitch while qualifying (counter at 5)
    restart(1'b0);
    tick(4);
    chk("t2_pulse_lo", bus.pll_rst, 0);
    bus.pll_locked = 1'b1;
    tick(6);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.sys_rst !== 1'b1 || bus.pll_rst !== 1'b0 || bus.ready !== 1'b0) bad = 1'b1;
    end
    chk("t2_held_in_reset", bad, 0);
    tick(1);
    chk("t2_ready", bus.ready, 1);
    chk("t2_sys_rst", bus.sys_rst, 0);

    // 3: lock timeout, retry, FAULT, clear_fault
    restart(1'b0);
    tick(4);
    chk("t3_pulse1_lo", bus.pll_rst, 0);
    tick(31);
    chk("t3_wait1_lo", bus.pll_rst, 0);
    tick(1);
    chk("t3_retry_pulse", bus.pll_rst, 1);
    chk("t3_no_fault1", bus.fault, 0);
    tick(3);
    chk("t3_retry_hi", bus.pll_rst, 1);
    tick(1);
    chk("t3_retry_lo", bus.pll_rst, 0);
    tick(31);
    chk("t3_wait2_fault", bus.fault, 0);
    tick(1);
    chk("t3_fault", bus.fault, 1);
    chk("t3_fault_pll", bus.pll_rst, 1);
    chk("t3_fault_sys", bus.sys_rst, 1);
    chk("t3_fault_ready", bus.ready, 0);
    tick(5);
    chk("t3_fault_hold", bus.fault, 1);
    bus.clear_fault = 1'b1;
    tick(1);
    bus.clear_fault = 1'b0;
    chk("t3_cleared", bus.fault, 0);
    chk("t3_clr_pll", bus.pll_rst, 1);
    tick(3);
    chk("t3_clr_pulse_hi", bus.pll_rst, 1);
    tick(1);
    chk("t3_clr_pulse_lo", bus.pll_rst, 0);
    tick(32);
    chk("t3_retry_reset", bus.pll_rst, 1);
    chk("t3_retry_reset_nf", bus.fault, 0);

    // 6a: lock arrives on the timeout cycle of the last allowed attempt
    restart(1'b0);
    tick(4);
    tick(32);
    chk("t6_retry_pulse", bus.pll_rst, 1);
    tick(4);
    chk("t6_wait2_lo", bus.pll_rst, 0);
    tick(29);
    bus.pll_locked = 1'b1;
    tick(10);
    chk("t6_ready_early", bus.ready, 0);
    chk("t6_no_fault", bus.fault, 0);
    tick(1);
    chk("t6_ready", bus.ready, 1);
    chk("t6_fault", bus.fault, 0);
    chk("t6_pll_rst", bus.pll_rst, 0);

    // 4: lock loss in RUN, then retry count must have been cleared on RUN entry
    bus.pll_locked = 1'b0;
    tick(2);
    chk("t4_loss_early_sys", bus.sys_rst, 0);
    chk("t4_loss_early_rdy", bus.ready, 1);
    tick(1);
    chk("t4_loss_sys", bus.sys_rst, 1);
    chk("t4_loss_ready", bus.ready, 0);
    chk("t4_loss_pll", bus.pll_rst, 1);
    chk("t4_loss_relock", bus.relock_cnt, 1);
    tick(4);
    chk("t4_pulse_lo", bus.pll_rst, 0);
    tick(31);
    chk("t4_wait_lo", bus.pll_rst, 0);
    tick(1);
    chk("t4_retry_not_fault", bus.fault, 0);
    chk("t4_retry_pulse", bus.pll_rst, 1);

    // 4: relock counter saturation
    restart(1'b1);
    wait_ready(40, ok);
    chk("t4_sat_bringup", ok, 1);
    bad = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      bus.pll_locked = 1'b0;
      tick(3);
      if (bus.sys_rst !== 1'b1 || bus.ready !== 1'b0) bad = 1'b1;
      bus.pll_locked = 1'b1;
      if (i == 254) chk("t4_relock_254", bus.relock_cnt, 254);
      if (i == 255) chk("t4_relock_255", bus.relock_cnt, 255);
      wait_ready(40, ok);
      if (!ok) begin
        chk("t4_relock_ready", ok, 1);
        break;
      end
    end
    chk("t4_loss_each", bad, 0);
    chk("t4_relock_sat", bus.relock_cnt, 255);

    // 5: rst pulse in RUN
    rst = 1'b1;
    tick(1);
    check_restart("t5_run");

    // 5: rst pulse in STABLE after one lock loss
    bus.pll_locked = 1'b0;
    tick(3);
    chk("t5_relock_pre", bus.relock_cnt, 1);
    bus.pll_locked = 1'b1;
    tick(6);
    chk("t5_stable_sys", bus.sys_rst, 1);
    chk("t5_stable_pll", bus.pll_rst, 0);
    rst = 1'b1;
    tick(1);
    check_restart("t5_stable");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
